// File: rtl/cpu24_pkg.sv
// cpu24_pkg
//   Shared constants and types for the 24-bit CPU front end.
//   INSTR_W / ADDR_W      : instruction word and word-address widths
//   OPCODE_W/MSB/LSB      : location of the opcode field inside an instruction
//   fetch_entry_t         : one prefetch buffer entry, {pc, instr}
package cpu24_pkg;

  localparam int INSTR_W    = 24;
  localparam int ADDR_W     = 10;
  localparam int OPCODE_W   = 4;
  localparam int OPCODE_MSB = 23;
  localparam int OPCODE_LSB = 20;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo
//   Synchronous FIFO with a synchronous clear, used as the instruction
//   prefetch buffer. Read data is the current head (first-word fall-through
//   view of registered storage), so a word written in cycle t is visible at t+1.
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   clr             : synchronous flush; wins over push and pop
//   push, push_data : write one entry (must not be full)
//   pop             : remove the head entry (must not be empty)
//   pop_data        : head entry
//   empty, full     : occupancy flags
//   count           : number of stored entries, 0..DEPTH
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 34
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 pop_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= push_data;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && !clr) begin
      assert (!(push && full && !pop));
      assert (!(pop && empty));
    end
  end
`endif

endmodule

// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit
//   Instruction fetch stage: issues in-order word requests to instruction
//   memory, buffers returned words with their PCs in a prefetch FIFO and
//   hands {pc, instr, opcode} to decode over valid/ready. A branch redirect
//   flushes the buffer, restarts fetch at the target and discards the
//   responses of requests that were already in flight.
// Ports
//   clk, rst                       : clock, synchronous active-high reset
//   imem_req_valid/ready/addr      : fetch request channel
//   imem_rsp_valid/data            : in-order response channel, never stalled
//   redirect_valid/pc              : taken-branch restart from the datapath
//   out_valid/ready                : decode handshake
//   out_instr/pc/opcode            : head instruction, its address and opcode
module instr_prefetch_unit #(
  parameter int                INSTR_W  = 24,
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [3:0]         out_opcode
);

  import cpu24_pkg::*;

  localparam int                CNT_W   = $clog2(DEPTH+1);
  localparam logic [CNT_W:0]    CREDITS = (CNT_W+1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  inflight_nxt;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              fifo_empty;
  logic              fifo_full;
  logic              req_fire;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  // Every buffered word and every outstanding request holds one credit, so
  // the FIFO can always absorb all responses still on their way.
  assign credit_used    = {1'b0, fifo_count} + {1'b0, inflight};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < CREDITS);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response in a redirect cycle is stale by definition; it is retired
  // without being buffered.
  assign push             = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign push_entry.pc    = resp_pc;
  assign push_entry.instr = imem_rsp_data;

  assign out_valid  = !fifo_empty;
  assign pop        = out_valid && out_ready;
  assign out_instr  = out_valid ? head_entry.instr : '0;
  assign out_pc     = out_valid ? head_entry.pc    : '0;
  assign out_opcode = out_instr[OPCODE_MSB:OPCODE_LSB];

  always_comb begin
    inflight_nxt = inflight;
    if (req_fire && !imem_rsp_valid)      inflight_nxt = inflight + 1'b1;
    else if (!req_fire && imem_rsp_valid) inflight_nxt = inflight - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        // Everything still outstanding after this cycle belongs to the old path.
        drop_cnt <= inflight_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 1'b1;
        if (imem_rsp_valid) begin
          if (drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
          else                resp_pc  <= resp_pc + 1'b1;
        end
      end
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && fifo_full));
      assert (inflight <= CNT_W'(DEPTH));
      assert (drop_cnt <= CNT_W'(DEPTH));
      assert (!(imem_rsp_valid && inflight == '0));
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// tb_instr_prefetch_unit
//   Self-checking bench for instr_prefetch_unit. A queue-based reference model
//   (buffered words, outstanding requests tagged stale/fresh) predicts every
//   output each cycle; directed scenarios add literal expectations, followed
//   by a randomized phase.
module tb_instr_prefetch_unit;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 24;
  localparam int PC_MOD  = 1 << ADDR_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [3:0]         out_opcode;

  instr_prefetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_opcode     (out_opcode)
  );

  always #5 clk = ~clk;

  typedef struct { int pc; logic [INSTR_W-1:0] instr; } ent_t;
  typedef struct { int pc; bit stale; } req_t;
  typedef struct { int due; int addr; } sched_t;

  ent_t   fifo_q[$];
  req_t   infl_q[$];
  sched_t sched_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  int n_deliv = 0;
  int lat_min = 1;
  int lat_max = 1;
  int m_fetch_pc = 0;
  logic [INSTR_W-1:0] mem_salt = '0;

  logic               s_out_valid;
  logic [ADDR_W-1:0]  s_out_pc;
  logic [INSTR_W-1:0] s_out_instr;
  logic               s_req_valid;
  logic [ADDR_W-1:0]  s_req_addr;

  function automatic logic [INSTR_W-1:0] mem_word(input int a);
    logic [31:0] p;
    p = a * 32'h0001_0101;
    return p[INSTR_W-1:0] ^ mem_salt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive the memory response, compare against the model,
  // then advance the model on the rising edge.
  task automatic cycle();
    bit     exp_rv;
    bit     acc_m;
    bit     acc_d;
    req_t   r;
    int     d;
    logic [INSTR_W-1:0] hi;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (sched_q.size() > 0 && sched_q[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(sched_q[0].addr);
    end
    #1;
    exp_rv = !rst && !redirect_valid && (fifo_q.size() + infl_q.size() < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", 32'(imem_req_addr), 32'(m_fetch_pc));
    chk("out_valid", 32'(out_valid), 32'(fifo_q.size() > 0));
    if (fifo_q.size() > 0) begin
      hi = fifo_q[0].instr;
      chk("out_pc", 32'(out_pc), 32'(fifo_q[0].pc));
      chk("out_instr", 32'(out_instr), 32'(hi));
      chk("out_opcode", 32'(out_opcode), 32'(hi[23:20]));
    end
    s_out_valid = out_valid;
    s_out_pc    = out_pc;
    s_out_instr = out_instr;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    acc_m = exp_rv && imem_req_ready;
    acc_d = imem_req_valid && imem_req_ready && !rst;
    @(posedge clk);
    if (rst) begin
      fifo_q.delete();
      infl_q.delete();
      sched_q.delete();
      m_fetch_pc = 0;
    end else begin
      if (fifo_q.size() > 0 && out_ready) begin
        n_deliv++;
        void'(fifo_q.pop_front());
      end
      if (imem_rsp_valid) begin
        void'(sched_q.pop_front());
        if (infl_q.size() > 0) begin
          r = infl_q.pop_front();
          if (!r.stale && !redirect_valid) fifo_q.push_back('{r.pc, mem_word(r.pc)});
        end
      end
      if (redirect_valid) begin
        fifo_q.delete();
        foreach (infl_q[i]) infl_q[i].stale = 1'b1;
        m_fetch_pc = int'(redirect_pc);
      end
      if (acc_m) begin
        infl_q.push_back('{m_fetch_pc, 1'b0});
        m_fetch_pc = (m_fetch_pc + 1) % PC_MOD;
      end
      if (acc_d) begin
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (sched_q.size() > 0 && d <= sched_q[$].due) d = sched_q[$].due + 1;
        sched_q.push_back('{d, int'(s_req_addr)});
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    n_deliv = 0;
  endtask

  initial begin
    int accepts;
    int found;
    int addrs[3];
    int na;
    logic [ADDR_W-1:0] a0;

    rst = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Streaming with single-cycle memory: one instruction per cycle.
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("t1_valid", 32'(s_out_valid), 32'(k >= 2));
      if (k >= 2) chk("t1_pc", 32'(s_out_pc), 32'(k - 2));
      if (k == 4) chk("t1_instr", 32'(s_out_instr), 32'h0002_0202);
    end

    // Decode stalled: exactly DEPTH requests, then release in order.
    do_reset();
    out_ready = 1'b0;
    accepts = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (s_req_valid && imem_req_ready) accepts++;
    end
    chk("t2_accepts", 32'(accepts), 32'(DEPTH));
    chk("t2_req_idle", 32'(s_req_valid), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t2_valid", 32'(s_out_valid), 32'd1);
      chk("t2_pc", 32'(s_out_pc), 32'(k));
    end

    // Memory stalls: request address must hold.
    imem_req_ready = 1'b0;
    repeat (3) cycle();
    a0 = s_req_addr;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t3_req_valid", 32'(s_req_valid), 32'd1);
      chk("t3_addr_hold", 32'(s_req_addr), 32'(a0));
    end
    imem_req_ready = 1'b1;
    repeat (10) cycle();

    // Redirect with two requests in flight at latency 3.
    do_reset();
    lat_min = 3; lat_max = 3;
    cycle();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 10'h200;
    cycle();
    chk("t4_no_req", 32'(s_req_valid), 32'd0);
    redirect_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      cycle();
      if (s_out_valid) found = 1;
    end
    chk("t4_found", 32'(found), 32'd1);
    chk("t4_pc", 32'(s_out_pc), 32'h200);
    chk("t4_instr", 32'(s_out_instr), 32'h02_0200);

    // Redirect coinciding with a pop and a response.
    do_reset();
    lat_min = 2; lat_max = 2;
    repeat (5) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 10'h155;
    cycle();
    chk("t5_pop_valid", 32'(s_out_valid), 32'd1);
    chk("t5_pop_pc", 32'(s_out_pc), 32'd2);
    redirect_valid = 1'b0;
    cycle();
    chk("t5_empty", 32'(s_out_valid), 32'd0);
    chk("t5_delivered", 32'(n_deliv), 32'd3);
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      cycle();
      if (s_out_valid) found = 1;
    end
    chk("t5_found", 32'(found), 32'd1);
    chk("t5_pc", 32'(s_out_pc), 32'h155);

    // PC wrap and reset in mid-stream.
    lat_min = 1; lat_max = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 10'h3FE;
    cycle();
    redirect_valid = 1'b0;
    na = 0;
    for (int k = 0; k < 20 && na < 3; k++) begin
      cycle();
      if (s_req_valid && imem_req_ready) begin
        addrs[na] = int'(s_req_addr);
        na++;
      end
    end
    chk("t6_naccept", 32'(na), 32'd3);
    chk("t6_addr0", 32'(addrs[0]), 32'h3FE);
    chk("t6_addr1", 32'(addrs[1]), 32'h3FF);
    chk("t6_addr2", 32'(addrs[2]), 32'h000);
    repeat (4) cycle();
    rst = 1'b1;
    cycle();
    cycle();
    chk("t6_rst_out_valid", 32'(s_out_valid), 32'd0);
    chk("t6_rst_out_pc", 32'(s_out_pc), 32'd0);
    chk("t6_rst_out_instr", 32'(s_out_instr), 32'd0);
    chk("t6_rst_req_valid", 32'(s_req_valid), 32'd0);
    rst = 1'b0;
    n_deliv = 0;
    cycle();
    chk("t6_restart_valid", 32'(s_req_valid), 32'd1);
    chk("t6_restart_addr", 32'(s_req_addr), 32'd0);

    // Randomized traffic.
    mem_salt = INSTR_W'($urandom);
    lat_min = 1; lat_max = 4;
    for (int k = 0; k < 3000; k++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = ADDR_W'($urandom);
      rst            = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    repeat (5) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
